// File: rtl/riscv_core.sv
// RV32I-subset 5-stage in-order core (IF, ID, EX, MEM, WB) with an internal
// instruction ROM, write-first register file and EX/MEM + MEM/WB forwarding.

package riscv_pkg;
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_LUI
    } alu_op_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);
    logic [31:0] registers [0:31];
    logic        wr_s;

    assign wr_s = we && (rd_addr != 5'd0);

    // Write port; x0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else if (wr_s) begin
            registers[rd_addr] <= rd_data;
        end
    end

    // Read ports see a same-cycle WB write (write-first bypass).
    always_comb begin
        rs1_data = registers[rs1_addr];
        rs2_data = registers[rs2_addr];
        if (wr_s && (rd_addr == rs1_addr)) rs1_data = rd_data;
        else                               rs1_data = registers[rs1_addr];
        if (wr_s && (rd_addr == rs2_addr)) rs2_data = rd_data;
        else                               rs2_data = registers[rs2_addr];
    end
endmodule

module decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [4:0]  ex_rs1_r,
    output logic [4:0]  ex_rs2_r,
    output logic [31:0] ex_rs1_val_r,
    output logic [31:0] ex_rs2_val_r,
    output logic [31:0] ex_imm_r,
    output logic        ex_use_imm_r,
    output alu_op_e     ex_alu_op_r,
    output logic [4:0]  ex_rd_r,
    output logic        ex_regwrite_r
);
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] imm_s;
    logic        use_imm_s;
    logic        regwrite_s;
    alu_op_e     alu_op_s;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];
    assign funct3_s = instr[14:12];
    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];
    assign funct7_s = instr[31:25];

    register_file register_file_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_s),
        .rs2_addr (rs2_s),
        .rs1_data (rs1_val_s),
        .rs2_data (rs2_val_s),
        .we       (wb_we),
        .rd_addr  (wb_rd),
        .rd_data  (wb_data)
    );

    // Instruction decode; anything unrecognised becomes a non-writing NOP.
    always_comb begin
        alu_op_s   = ALU_ADD;
        use_imm_s  = 1'b0;
        regwrite_s = 1'b0;
        imm_s      = 32'd0;
        case (opcode_s)
            7'h33: begin
                regwrite_s = 1'b1;
                case ({funct7_s, funct3_s})
                    {7'h00, 3'b000}: alu_op_s = ALU_ADD;
                    {7'h20, 3'b000}: alu_op_s = ALU_SUB;
                    {7'h00, 3'b111}: alu_op_s = ALU_AND;
                    {7'h00, 3'b110}: alu_op_s = ALU_OR;
                    {7'h00, 3'b100}: alu_op_s = ALU_XOR;
                    {7'h00, 3'b010}: alu_op_s = ALU_SLT;
                    default:         regwrite_s = 1'b0;
                endcase
            end
            7'h13: begin
                regwrite_s = 1'b1;
                use_imm_s  = 1'b1;
                imm_s      = {{20{instr[31]}}, instr[31:20]};
                case (funct3_s)
                    3'b000:  alu_op_s = ALU_ADD;
                    3'b111:  alu_op_s = ALU_AND;
                    3'b110:  alu_op_s = ALU_OR;
                    3'b100:  alu_op_s = ALU_XOR;
                    3'b010:  alu_op_s = ALU_SLT;
                    default: regwrite_s = 1'b0;
                endcase
            end
            7'h37: begin
                regwrite_s = 1'b1;
                use_imm_s  = 1'b1;
                imm_s      = {instr[31:12], 12'd0};
                alu_op_s   = ALU_LUI;
            end
            default: regwrite_s = 1'b0;
        endcase
    end

    // ID/EX pipeline register; writes to x0 are dropped here so they never forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_r      <= 5'd0;
            ex_rs2_r      <= 5'd0;
            ex_rs1_val_r  <= 32'd0;
            ex_rs2_val_r  <= 32'd0;
            ex_imm_r      <= 32'd0;
            ex_use_imm_r  <= 1'b0;
            ex_alu_op_r   <= ALU_ADD;
            ex_rd_r       <= 5'd0;
            ex_regwrite_r <= 1'b0;
        end else begin
            ex_rs1_r      <= rs1_s;
            ex_rs2_r      <= rs2_s;
            ex_rs1_val_r  <= rs1_val_s;
            ex_rs2_val_r  <= rs2_val_s;
            ex_imm_r      <= imm_s;
            ex_use_imm_r  <= use_imm_s;
            ex_alu_op_r   <= alu_op_s;
            ex_rd_r       <= rd_s;
            ex_regwrite_r <= regwrite_s && (rd_s != 5'd0);
        end
    end
endmodule

module riscv_core
    import riscv_pkg::*;
#(
    parameter int    IMEM_DEPTH = 64,
    parameter string IMEM_FILE  = ""
) (
    input  logic clk,
    input  logic rst_n
);
    localparam int          AW       = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

    logic [31:0] imem [0:IMEM_DEPTH-1];

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] ifid_instr_r;

    logic [4:0]  ex_rs1_s;
    logic [4:0]  ex_rs2_s;
    logic [31:0] ex_rs1_val_s;
    logic [31:0] ex_rs2_val_s;
    logic [31:0] ex_imm_s;
    logic        ex_use_imm_s;
    alu_op_e     ex_alu_op_s;
    logic [4:0]  ex_rd_s;
    logic        ex_regwrite_s;

    logic [31:0] fwd_a_s;
    logic [31:0] fwd_b_s;
    logic [31:0] op_b_s;
    logic [31:0] alu_result_s;

    logic [4:0]  exmem_rd_r;
    logic        exmem_regwrite_r;
    logic [31:0] exmem_result_r;
    logic [4:0]  memwb_rd_r;
    logic        memwb_regwrite_r;
    logic [31:0] memwb_result_r;

    // ROM image: default boot program.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = NOP_INSTR;
        imem[0] = 32'h0010_0193;
        imem[1] = 32'h0040_0213;
        imem[2] = 32'h0041_82B3;
    end

    assign pc_next_s = (pc_r >= (PC_LIMIT - 32'd4)) ? 32'd0 : (pc_r + 32'd4);

    // Fetch: PC and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= 32'd0;
            ifid_instr_r <= NOP_INSTR;
        end else begin
            pc_r         <= pc_next_s;
            ifid_instr_r <= imem[pc_r[AW+1:2]];
        end
    end

    decode_stage decode_stage_inst (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (ifid_instr_r),
        .wb_we         (memwb_regwrite_r),
        .wb_rd         (memwb_rd_r),
        .wb_data       (memwb_result_r),
        .ex_rs1_r      (ex_rs1_s),
        .ex_rs2_r      (ex_rs2_s),
        .ex_rs1_val_r  (ex_rs1_val_s),
        .ex_rs2_val_r  (ex_rs2_val_s),
        .ex_imm_r      (ex_imm_s),
        .ex_use_imm_r  (ex_use_imm_s),
        .ex_alu_op_r   (ex_alu_op_s),
        .ex_rd_r       (ex_rd_s),
        .ex_regwrite_r (ex_regwrite_s)
    );

    // Operand forwarding (EX/MEM beats MEM/WB) and the ALU.
    always_comb begin
        if (exmem_regwrite_r && (exmem_rd_r != 5'd0) && (exmem_rd_r == ex_rs1_s))
            fwd_a_s = exmem_result_r;
        else if (memwb_regwrite_r && (memwb_rd_r != 5'd0) && (memwb_rd_r == ex_rs1_s))
            fwd_a_s = memwb_result_r;
        else
            fwd_a_s = ex_rs1_val_s;

        if (exmem_regwrite_r && (exmem_rd_r != 5'd0) && (exmem_rd_r == ex_rs2_s))
            fwd_b_s = exmem_result_r;
        else if (memwb_regwrite_r && (memwb_rd_r != 5'd0) && (memwb_rd_r == ex_rs2_s))
            fwd_b_s = memwb_result_r;
        else
            fwd_b_s = ex_rs2_val_s;

        op_b_s = ex_use_imm_s ? ex_imm_s : fwd_b_s;

        case (ex_alu_op_s)
            ALU_ADD: alu_result_s = fwd_a_s + op_b_s;
            ALU_SUB: alu_result_s = fwd_a_s - op_b_s;
            ALU_AND: alu_result_s = fwd_a_s & op_b_s;
            ALU_OR:  alu_result_s = fwd_a_s | op_b_s;
            ALU_XOR: alu_result_s = fwd_a_s ^ op_b_s;
            ALU_SLT: alu_result_s = {31'd0, ($signed(fwd_a_s) < $signed(op_b_s))};
            ALU_LUI: alu_result_s = op_b_s;
            default: alu_result_s = 32'd0;
        endcase
    end

    // EX/MEM and MEM/WB registers; MEM does no work beyond carrying the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_rd_r       <= 5'd0;
            exmem_regwrite_r <= 1'b0;
            exmem_result_r   <= 32'd0;
            memwb_rd_r       <= 5'd0;
            memwb_regwrite_r <= 1'b0;
            memwb_result_r   <= 32'd0;
        end else begin
            exmem_rd_r       <= ex_rd_s;
            exmem_regwrite_r <= ex_regwrite_s;
            exmem_result_r   <= alu_result_s;
            memwb_rd_r       <= exmem_rd_r;
            memwb_regwrite_r <= exmem_regwrite_r;
            memwb_result_r   <= exmem_result_r;
        end
    end
endmodule

// File: tb/tb_riscv_core.sv
// Self-checking bench for riscv_core: directed and random programs compared
// every cycle against an in-order architectural reference model.

module tb_riscv_core;
    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    riscv_core #(.IMEM_DEPTH(DEPTH), .IMEM_FILE("")) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          edges   = 0;
    logic [31:0] prog  [0:DEPTH-1];
    logic [31:0] mregs [0:31];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'h37};
    endfunction

    // Architectural effect of one instruction, straight from the ISA rules.
    task automatic model_exec(input logic [31:0] w);
        logic [31:0] a, b, immi, r;
        logic [4:0]  rd;
        bit          wr;
        a    = mregs[w[19:15]];
        b    = mregs[w[24:20]];
        immi = {{20{w[31]}}, w[31:20]};
        rd   = w[11:7];
        wr   = 1'b0;
        r    = 32'd0;
        if (w[6:0] == 7'h33) begin
            if (w[31:25] == 7'h20 && w[14:12] == 3'd0) begin r = a - b; wr = 1'b1; end
            else if (w[31:25] == 7'h00) begin
                wr = 1'b1;
                case (w[14:12])
                    3'd0: r = a + b;
                    3'd7: r = a & b;
                    3'd6: r = a | b;
                    3'd4: r = a ^ b;
                    3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
        end else if (w[6:0] == 7'h13) begin
            wr = 1'b1;
            case (w[14:12])
                3'd0: r = a + immi;
                3'd7: r = a & immi;
                3'd6: r = a | immi;
                3'd4: r = a ^ immi;
                3'd2: r = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                default: wr = 1'b0;
            endcase
        end else if (w[6:0] == 7'h37) begin
            r  = {w[31:12], 12'd0};
            wr = 1'b1;
        end
        if (wr && rd != 5'd0) mregs[rd] = r;
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 32; i++)
            check_val($sformatf("%s x%0d", tag, i),
                      dut.decode_stage_inst.register_file_inst.registers[i], mregs[i]);
    endtask

    // One clock: instruction k retires on edge k+5 after reset release.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        edges++;
        if (edges >= 5) model_exec(prog[(edges - 5) % DEPTH]);
        compare_all($sformatf("%s@%0d", tag, edges));
    endtask

    task automatic enter_reset(input string tag);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        edges = 0;
        compare_all({tag, " rst"});
        check_val({tag, " rst pc"}, dut.pc_r, 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_prog(input logic [31:0] words[$]);
        for (int i = 0; i < DEPTH; i++) begin
            prog[i] = (i < words.size()) ? words[i] : NOP;
            dut.imem[i] = prog[i];
        end
    endtask

    task automatic run_prog(input string tag, input logic [31:0] words[$], input int n);
        enter_reset(tag);
        load_prog(words);
        release_reset();
        for (int c = 0; c < n; c++) tick(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [2:0] f3_list [0:4];
        logic [2:0] f3;
        logic [6:0] f7;
        f3_list[0] = 3'd0; f3_list[1] = 3'd7; f3_list[2] = 3'd6;
        f3_list[3] = 3'd4; f3_list[4] = 3'd2;
        f3 = f3_list[$urandom_range(0, 4)];
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
                f7 = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_r(f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
                             5'($urandom_range(0, 7)));
            end
            4, 5, 6: return enc_i(12'($urandom), 5'($urandom_range(0, 7)), f3,
                                  5'($urandom_range(0, 7)));
            7:       return enc_u(20'($urandom), 5'($urandom_range(0, 7)));
            8:       return 32'($urandom);
            default: return enc_r(7'h01, 5'd1, 5'd2, 3'd0, 5'($urandom_range(1, 7)));
        endcase
    endfunction

    function automatic logic [31:0] reg_of(input int i);
        return dut.decode_stage_inst.register_file_inst.registers[i];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1);
    end

    initial begin
        logic [31:0] q [$];
        #2;
        // Default boot ROM, untouched by the bench.
        for (int i = 0; i < DEPTH; i++) prog[i] = NOP;
        prog[0] = 32'h0010_0193;
        prog[1] = 32'h0040_0213;
        prog[2] = 32'h0041_82B3;
        enter_reset("boot");
        release_reset();
        for (int c = 0; c < 10; c++) tick("boot");
        check_val("boot x3", reg_of(3), 32'd1);
        check_val("boot x4", reg_of(4), 32'd4);
        check_val("boot x5", reg_of(5), 32'd5);
        check_val("boot x0", reg_of(0), 32'd0);

        // Mid-run reset clears state at once; the program then reruns from PC 0.
        for (int c = 0; c < 2; c++) tick("boot2");
        check_val("pre-reset x3", reg_of(3), 32'd1);
        enter_reset("midrst");
        release_reset();
        for (int c = 0; c < 7; c++) tick("rerun");
        check_val("rerun x3", reg_of(3), 32'd1);
        check_val("rerun x4", reg_of(4), 32'd4);
        check_val("rerun x5", reg_of(5), 32'd5);

        q = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), enc_i(12'd3, 5'd1, 3'd0, 5'd2),
              enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd6)};
        run_prog("dep", q, 10);
        check_val("dep x1", reg_of(1), 32'hFFFF_FFFF);
        check_val("dep x2", reg_of(2), 32'd2);
        check_val("dep x6", reg_of(6), 32'd3);

        q = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), enc_i(12'h0F0, 5'd0, 3'd0, 5'd7),
              enc_i(12'h0FF, 5'd0, 3'd0, 5'd8), enc_r(7'h00, 5'd8, 5'd7, 3'd7, 5'd9),
              enc_r(7'h00, 5'd8, 5'd7, 3'd4, 5'd10), enc_i(12'd0, 5'd1, 3'd2, 5'd11),
              enc_u(20'h12345, 5'd12)};
        run_prog("logic", q, 14);
        check_val("logic x9", reg_of(9), 32'h0000_00F0);
        check_val("logic x10", reg_of(10), 32'h0000_000F);
        check_val("logic x11", reg_of(11), 32'd1);
        check_val("logic x12", reg_of(12), 32'h1234_5000);

        q = '{enc_i(12'd5, 5'd0, 3'd0, 5'd0), enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd13)};
        run_prog("x0", q, 10);
        check_val("x0 x0", reg_of(0), 32'd0);
        check_val("x0 x13", reg_of(13), 32'd0);

        q = '{enc_i(12'd7, 5'd0, 3'd0, 5'd1), 32'hFFFF_FFFF, enc_i(12'd9, 5'd1, 3'd0, 5'd2)};
        run_prog("illegal", q, 10);
        check_val("illegal x1", reg_of(1), 32'd7);
        check_val("illegal x2", reg_of(2), 32'd16);

        // Random programs long enough to wrap the PC past the end of the ROM.
        for (int t = 0; t < 6; t++) begin
            q.delete();
            for (int i = 0; i < DEPTH; i++) q.push_back(rand_instr());
            run_prog($sformatf("rand%0d", t), q, 80);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
